// File: rtl/button_event_classifier_if.sv
// Event handshake between the button classifier and its consumer.
// Ports: event_valid/event_code (producer), event_ready (consumer).
interface button_event_classifier_if;
   logic       event_valid;
   logic       event_ready;
   logic [1:0] event_code;

   modport master (
      output event_valid,
      output event_code,
      input  event_ready
   );

   modport slave (
      input  event_valid,
      input  event_code,
      output event_ready
   );
endinterface

// File: rtl/button_event_classifier.sv
// Classifies debounced button presses into SHORT / LONG / DOUBLE events.
// Ports: i_clk, i_rst (async high), i_tick, i_button, ev (event handshake),
//        o_overflow (sticky drop flag), i_clr_overflow, o_pressed.
module button_event_classifier #(
   parameter int CNT_WIDTH  = 16,
   parameter int LONG_TICKS = 1000,
   parameter int GAP_TICKS  = 250
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_tick,
   input  logic i_button,
   button_event_classifier_if.master ev,
   output logic o_overflow,
   input  logic i_clr_overflow,
   output logic o_pressed
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] PRESS1 = 3'd1;
   localparam logic [2:0] GAP    = 3'd2;
   localparam logic [2:0] PRESS2 = 3'd3;
   localparam logic [2:0] HOLD   = 3'd4;

   localparam logic [1:0] C_SHORT  = 2'b01;
   localparam logic [1:0] C_LONG   = 2'b10;
   localparam logic [1:0] C_DOUBLE = 2'b11;

   localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_TICKS - 1);
   localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(GAP_TICKS - 1);

   logic [2:0]           state;
   logic [2:0]           state_nxt;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 btn_q;
   logic                 armed;
   logic                 valid_q;
   logic [1:0]           code_q;
   logic                 rise;
   logic                 fall;
   logic                 emit;
   logic [1:0]           emit_code;
   logic                 slot_free;

   // armed stays low after reset until the button is seen released, so a
   // button held across reset deassertion cannot fake a rising edge.
   assign rise = i_button & ~btn_q & armed;
   assign fall = ~i_button & btn_q;

   assign slot_free = ~valid_q | ev.event_ready;

   always_comb begin
      state_nxt = state;
      emit      = 1'b0;
      emit_code = 2'b00;
      case (state)
         IDLE: begin
            if (rise) state_nxt = PRESS1;
         end
         PRESS1: begin
            if (fall) begin
               state_nxt = GAP;
            end else if (i_tick && cnt == LONG_LAST) begin
               state_nxt = HOLD;
               emit      = 1'b1;
               emit_code = C_LONG;
            end
         end
         GAP: begin
            if (rise) begin
               state_nxt = PRESS2;
            end else if (i_tick && cnt == GAP_LAST) begin
               state_nxt = IDLE;
               emit      = 1'b1;
               emit_code = C_SHORT;
            end
         end
         PRESS2: begin
            if (fall) begin
               state_nxt = IDLE;
               emit      = 1'b1;
               emit_code = C_DOUBLE;
            end
         end
         HOLD: begin
            if (fall) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= IDLE;
         cnt   <= '0;
         btn_q <= 1'b0;
         armed <= 1'b0;
      end else begin
         state <= state_nxt;
         btn_q <= i_button;
         if (~i_button) armed <= 1'b1;
         // Counter restarts on every transition and saturates instead of wrapping.
         if (state_nxt != state) begin
            cnt <= '0;
         end else if (i_tick && cnt != '1) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         valid_q    <= 1'b0;
         code_q     <= 2'b00;
         o_overflow <= 1'b0;
      end else begin
         if (emit && slot_free) begin
            valid_q <= 1'b1;
            code_q  <= emit_code;
         end else if (valid_q && ev.event_ready) begin
            valid_q <= 1'b0;
         end
         // A drop in the same cycle as a clear must leave the flag set.
         if (emit && !slot_free) begin
            o_overflow <= 1'b1;
         end else if (i_clr_overflow) begin
            o_overflow <= 1'b0;
         end
      end
   end

   assign ev.event_valid = valid_q;
   assign ev.event_code  = code_q;
   assign o_pressed      = btn_q;

endmodule

// File: tb/tb_button_event_classifier.sv
// Scoreboard bench for button_event_classifier (LONG_TICKS=4, GAP_TICKS=3).
// Expected codes are queued at stimulus time and popped on each accepted event.
module tb_button_event_classifier;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tick = 1'b0;
   logic button = 1'b0;
   logic clr_ovf = 1'b0;
   logic overflow;
   logic pressed;

   int total = 0;
   int bad = 0;
   logic [1:0] sb_q[$];

   button_event_classifier_if ev ();

   button_event_classifier #(
      .CNT_WIDTH (16),
      .LONG_TICKS(4),
      .GAP_TICKS (3)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_tick        (tick),
      .i_button      (button),
      .ev            (ev.master),
      .o_overflow    (overflow),
      .i_clr_overflow(clr_ovf),
      .o_pressed     (pressed)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock: drive inputs, take the edge, settle 1 time unit after it.
   task automatic step(input logic t, input logic b);
      tick   = t;
      button = b;
      @(posedge clk);
      #1;
      tick    = 1'b0;
      clr_ovf = 1'b0;
   endtask

   // Scoreboard: compare every accepted event against the queued expectation.
   always @(negedge clk) begin
      if (!rst && ev.event_valid && ev.event_ready) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_event", {30'd0, ev.event_code}, 32'd0);
         end else begin
            chk("sb_code", {30'd0, ev.event_code}, {30'd0, sb_q.pop_front()});
         end
      end
   end

   initial begin
      ev.event_ready = 1'b1;
      #12;
      chk("rst_valid", {31'd0, ev.event_valid}, 0);
      chk("rst_code", {30'd0, ev.event_code}, 0);
      chk("rst_ovf", {31'd0, overflow}, 0);
      chk("rst_pressed", {31'd0, pressed}, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      step(0, 0);

      // 1: short press
      step(0, 1);
      chk("t1_pressed", {31'd0, pressed}, 1);
      step(1, 1);
      step(1, 1);
      step(0, 0);
      step(1, 0);
      step(1, 0);
      chk("t1_no_early", {31'd0, ev.event_valid}, 0);
      sb_q.push_back(2'b01);
      step(1, 0);
      chk("t1_valid", {31'd0, ev.event_valid}, 1);
      chk("t1_code", {30'd0, ev.event_code}, 2'b01);
      step(0, 0);
      chk("t1_one_cycle", {31'd0, ev.event_valid}, 0);

      // 2: long press, then extended hold
      step(0, 1);
      for (int i = 0; i < 3; i++) step(1, 1);
      chk("t2_no_early", {31'd0, ev.event_valid}, 0);
      sb_q.push_back(2'b10);
      step(1, 1);
      chk("t2_valid", {31'd0, ev.event_valid}, 1);
      chk("t2_code", {30'd0, ev.event_code}, 2'b10);
      for (int i = 0; i < 10; i++) step(1, 1);
      step(0, 0);
      for (int i = 0; i < 5; i++) step(1, 0);
      chk("t2_no_more", {31'd0, ev.event_valid}, 0);

      // 3: double click
      step(0, 1);
      step(1, 1);
      step(0, 0);
      step(1, 0);
      step(0, 1);
      sb_q.push_back(2'b11);
      step(0, 0);
      chk("t3_valid", {31'd0, ev.event_valid}, 1);
      chk("t3_code", {30'd0, ev.event_code}, 2'b11);
      for (int i = 0; i < 5; i++) step(1, 0);
      chk("t3_no_short", {31'd0, ev.event_valid}, 0);

      // 4: release coincides with the long threshold tick
      step(0, 1);
      for (int i = 0; i < 3; i++) step(1, 1);
      step(1, 0);
      chk("t4_no_long", {31'd0, ev.event_valid}, 0);
      step(1, 0);
      step(1, 0);
      chk("t4_no_early", {31'd0, ev.event_valid}, 0);
      sb_q.push_back(2'b01);
      step(1, 0);
      chk("t4_valid", {31'd0, ev.event_valid}, 1);
      chk("t4_code", {30'd0, ev.event_code}, 2'b01);
      step(0, 0);

      // 5: stalled consumer, overflow
      ev.event_ready = 1'b0;
      step(0, 1);
      step(1, 1);
      step(0, 0);
      sb_q.push_back(2'b01);
      for (int i = 0; i < 3; i++) step(1, 0);
      chk("t5_valid", {31'd0, ev.event_valid}, 1);
      chk("t5_code", {30'd0, ev.event_code}, 2'b01);
      chk("t5_ovf0", {31'd0, overflow}, 0);
      step(0, 1);
      for (int i = 0; i < 4; i++) step(1, 1);
      chk("t5_code_held", {30'd0, ev.event_code}, 2'b01);
      chk("t5_ovf1", {31'd0, overflow}, 1);
      step(0, 0);
      step(0, 0);
      chk("t5_still_valid", {31'd0, ev.event_valid}, 1);
      ev.event_ready = 1'b1;
      step(0, 0);
      chk("t5_drop", {31'd0, ev.event_valid}, 0);
      chk("t5_ovf_sticky", {31'd0, overflow}, 1);
      clr_ovf = 1'b1;
      step(0, 0);
      chk("t5_ovf_clr", {31'd0, overflow}, 0);

      // 6: async reset mid-press with button held
      step(0, 1);
      step(1, 1);
      chk("t6_pre_pressed", {31'd0, pressed}, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_rst_pressed", {31'd0, pressed}, 0);
      chk("t6_rst_valid", {31'd0, ev.event_valid}, 0);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 6; i++) step(1, 1);
      chk("t6_no_long", {31'd0, ev.event_valid}, 0);
      chk("t6_held", {31'd0, pressed}, 1);
      step(0, 0);
      for (int i = 0; i < 4; i++) step(1, 0);
      chk("t6_no_short", {31'd0, ev.event_valid}, 0);
      step(0, 1);
      step(1, 1);
      step(0, 0);
      step(1, 0);
      step(1, 0);
      sb_q.push_back(2'b01);
      step(1, 0);
      chk("t6_fresh_code", {30'd0, ev.event_code}, 2'b01);
      chk("t6_fresh_valid", {31'd0, ev.event_valid}, 1);
      step(0, 0);
      step(0, 0);

      chk("sb_empty", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
